// File: rtl/wave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wave_pkg
// Description : Shared definitions between the capture buffer and the wave
//               display engine: capture FSM encoding, h_shift sign
//               convention and the default window geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package wave_pkg;

  // Default window geometry; both sides of the read interface use these
  localparam int c_PRE_TRIG_DEFAULT    = 512;
  localparam int c_DISP_POINTS_DEFAULT = 900;

  // h_shift[9] value that moves the wave to the right (subtracts magnitude)
  localparam logic c_SHIFT_RIGHT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRE_FILL  = 3'd1,
    ST_ARMED     = 3'd2,
    ST_POST_FILL = 3'd3,
    ST_DONE      = 3'd4
  } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/wave_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : wave_capture_if
// Description : Display-side read bus of the capture buffer. The display
//               engine is the master (drives point index / frame end), the
//               capture buffer is the slave (returns sample + outrange).
// Revision    : 1.0 - initial release
// ============================================================================
interface wave_capture_if;
  logic        wave_data_req;
  logic [11:0] wave_addr;
  logic        wr_over;
  logic [7:0]  wave_data;
  logic        outrange;

  modport master (
    output wave_data_req,
    output wave_addr,
    output wr_over,
    input  wave_data,
    input  outrange
  );

  modport slave (
    input  wave_data_req,
    input  wave_addr,
    input  wr_over,
    output wave_data,
    output outrange
  );
endinterface
`default_nettype wire

// File: rtl/wave_ram.sv
`default_nettype none
// ============================================================================
// Module      : wave_ram
// Description : Simple dual-port sample RAM, one write port and one
//               registered read port. Read-first: a same-address read and
//               write in one cycle returns the old contents.
// Revision    : 1.0 - initial release
// ============================================================================
module wave_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  wire logic              clk,
  input  wire logic              we,
  input  wire logic [ADDR_W-1:0] waddr,
  input  wire logic [DATA_W-1:0] wdata,
  input  wire logic [ADDR_W-1:0] raddr,
  output logic      [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  // Write and registered read on the same edge; the read sees pre-write data
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
    r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/wave_capture.sv
`default_nettype none
// ============================================================================
// Module      : wave_capture
// Description : Circular ADC sample buffer with edge trigger. Freezes a
//               pre/post-trigger window and serves it to the wave display
//               engine; re-arms only on a finished display frame.
// Revision    : 1.0 - initial release
// ============================================================================
module wave_capture
  import wave_pkg::*;
#(
  parameter int          ADDR_W       = 10,
  parameter int          PRE_TRIG     = c_PRE_TRIG_DEFAULT,
  parameter int          DISP_POINTS  = c_DISP_POINTS_DEFAULT,
  parameter logic [15:0] AUTO_SAMPLES = 16'd65535
) (
  input  wire logic       hdmi_pclk,
  input  wire logic       rst_n,
  input  wire logic [7:0] ad_data,
  input  wire logic       ad_valid,
  input  wire logic       run,
  input  wire logic       trig_mode,
  input  wire logic       trig_edge,
  input  wire logic [7:0] trig_level,
  input  wire logic [9:0] h_shift,
  wave_capture_if.slave   disp,
  output logic            capture_done,
  output logic            trig_found
);

  localparam int c_DEPTH  = 1 << ADDR_W;
  localparam int c_CENTRE = (c_DEPTH - DISP_POINTS) / 2;
  localparam logic [ADDR_W-1:0] c_PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] c_POST_LAST = ADDR_W'(c_DEPTH - PRE_TRIG - 2);
  localparam logic [ADDR_W-1:0] c_PRE_OFS   = ADDR_W'(PRE_TRIG);

  cap_state_t        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_fill_cnt;   // pre-fill count, then post-fill count
  logic [15:0]       r_to_cnt;
  logic [7:0]        r_prev;
  logic [ADDR_W-1:0] r_trig_ptr;
  logic              r_trig_found;
  logic              r_has_frame;
  logic              r_oor;

  logic              w_we, w_restart, w_fire;
  logic              w_edge_hit, w_timeout;
  logic [12:0]       w_base, w_mag, w_l;
  logic              w_l_oor;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [7:0]        w_ram_q;

  // Trigger conditions on the current sample against the previous one
  assign w_edge_hit = trig_edge ? ((r_prev > trig_level) && (ad_data <= trig_level))
                                : ((r_prev < trig_level) && (ad_data >= trig_level));
  assign w_timeout  = !trig_mode && (r_to_cnt == AUTO_SAMPLES - 16'd1);

  // Capture FSM state register
  always_ff @(posedge hdmi_pclk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic and per-cycle control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_restart   = 1'b0;
    w_fire      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_restart = 1'b1;
        if (run) w_state_nxt = ST_PRE_FILL;
      end
      ST_PRE_FILL: begin
        if (!run) w_state_nxt = ST_IDLE;
        else begin
          w_we = ad_valid;
          if (ad_valid && r_fill_cnt == c_PRE_LAST) w_state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (!run) w_state_nxt = ST_IDLE;
        else begin
          w_we = ad_valid;
          if (ad_valid && (w_edge_hit || w_timeout)) begin
            w_fire      = 1'b1;
            w_state_nxt = ST_POST_FILL;
          end
        end
      end
      ST_POST_FILL: begin
        w_we = ad_valid;
        if (ad_valid && r_fill_cnt == c_POST_LAST) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (disp.wr_over && run) begin
          w_restart   = 1'b1;
          w_state_nxt = ST_PRE_FILL;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Write pointer, fill/timeout counters, trigger capture and frame flag
  always_ff @(posedge hdmi_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_fill_cnt   <= '0;
      r_to_cnt     <= 16'd0;
      r_prev       <= 8'd0;
      r_trig_ptr   <= '0;
      r_trig_found <= 1'b0;
      r_has_frame  <= 1'b0;
    end else begin
      if (w_restart) begin
        r_wr_ptr   <= '0;
        r_fill_cnt <= '0;
        r_to_cnt   <= 16'd0;
      end else begin
        if (w_we) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          r_prev   <= ad_data;
        end
        if (w_fire)    r_fill_cnt <= '0;
        else if (w_we) r_fill_cnt <= r_fill_cnt + 1'b1;
        if (w_we && r_state == ST_ARMED) r_to_cnt <= r_to_cnt + 16'd1;
      end
      if (w_fire) begin
        r_trig_ptr   <= r_wr_ptr;
        r_trig_found <= w_edge_hit;
      end
      if (r_state == ST_POST_FILL && w_state_nxt == ST_DONE) r_has_frame <= 1'b1;
    end
  end

  // Logical window index for the requested display point, 13-bit signed
  assign w_base    = {1'b0, disp.wave_addr} + 13'(c_CENTRE);
  assign w_mag     = {4'd0, h_shift[8:0]};
  assign w_l       = (h_shift[9] == c_SHIFT_RIGHT) ? (w_base - w_mag) : (w_base + w_mag);
  assign w_l_oor   = w_l[12] || (w_l[11:ADDR_W] != '0);
  assign w_rd_addr = (r_trig_ptr - c_PRE_OFS) + w_l[ADDR_W-1:0];

  wave_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (8)
  ) u_ram (
    .clk   (hdmi_pclk),
    .we    (w_we),
    .waddr (r_wr_ptr),
    .wdata (ad_data),
    .raddr (w_rd_addr),
    .rdata (w_ram_q)
  );

  // Out-of-range flag registered alongside the RAM read
  always_ff @(posedge hdmi_pclk or negedge rst_n) begin
    if (!rst_n) r_oor <= 1'b1;
    else        r_oor <= !disp.wave_data_req || !r_has_frame || w_l_oor;
  end

  assign disp.wave_data = r_oor ? 8'd0 : w_ram_q;
  assign disp.outrange  = r_oor;
  assign capture_done   = (r_state == ST_DONE);
  assign trig_found     = r_trig_found;

endmodule
`default_nettype wire

// File: tb/tb_wave_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_wave_capture
// Description : Self-checking bench for wave_capture. A sample-history model
//               finds the trigger from the edge/timeout rules and predicts
//               the frozen window and every display read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wave_capture;

  localparam int PRE    = 512;
  localparam int DEPTH  = 1024;
  localparam int CENTRE = 62;
  localparam int AUTO   = 65535;
  localparam int POST   = DEPTH - PRE - 1;

  logic       hdmi_pclk  = 1'b0;
  logic       rst_n      = 1'b0;
  logic [7:0] ad_data    = 8'd0;
  logic       ad_valid   = 1'b0;
  logic       run        = 1'b0;
  logic       trig_mode  = 1'b1;
  logic       trig_edge  = 1'b0;
  logic [7:0] trig_level = 8'd100;
  logic [9:0] h_shift    = 10'd0;
  logic       capture_done;
  logic       trig_found;

  wave_capture_if disp_if ();

  wave_capture dut (
    .hdmi_pclk    (hdmi_pclk),
    .rst_n        (rst_n),
    .ad_data      (ad_data),
    .ad_valid     (ad_valid),
    .run          (run),
    .trig_mode    (trig_mode),
    .trig_edge    (trig_edge),
    .trig_level   (trig_level),
    .h_shift      (h_shift),
    .disp         (disp_if),
    .capture_done (capture_done),
    .trig_found   (trig_found)
  );

  always #5 hdmi_pclk = ~hdmi_pclk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: history of accepted samples since the capture started
  logic [7:0] hist [$];
  logic [7:0] m_win [0:DEPTH-1];
  int         m_trig = -1;
  bit         m_forced, m_done, m_has_frame;
  bit         m_auto, m_falling;
  int         m_level;

  task automatic tick();
    @(posedge hdmi_pclk);
    #1;
  endtask

  task automatic model_push(input logic [7:0] v);
    int k;
    int p;
    if (m_done) return;
    hist.push_back(v);
    k = hist.size() - 1;
    if (m_trig < 0 && k >= PRE) begin
      p = hist[k-1];
      if (m_falling ? (p > m_level && int'(v) <= m_level)
                    : (p < m_level && int'(v) >= m_level)) begin
        m_trig = k; m_forced = 1'b0;
      end else if (m_auto && (k - PRE + 1) == AUTO) begin
        m_trig = k; m_forced = 1'b1;
      end
    end
    if (m_trig >= 0 && k == m_trig + POST) begin
      m_done = 1'b1;
      m_has_frame = 1'b1;
      for (int l = 0; l < DEPTH; l++) m_win[l] = hist[m_trig - PRE + l];
    end
  endtask

  task automatic feed(input logic [7:0] v, input logic valid);
    ad_data  = v;
    ad_valid = valid;
    tick();
    if (valid) model_push(v);
    ad_valid = 1'b0;
  endtask

  task automatic restart(input logic mode, input logic edge_sel, input logic [7:0] level);
    trig_mode  = mode;
    trig_edge  = edge_sel;
    trig_level = level;
    m_auto = !mode; m_falling = edge_sel; m_level = level;
    hist.delete(); m_trig = -1; m_forced = 1'b0;
    if (m_done) begin
      run = 1'b1; disp_if.wr_over = 1'b1; tick(); disp_if.wr_over = 1'b0;
    end else begin
      run = 1'b0; tick(); run = 1'b1; tick();
    end
    m_done = 1'b0;
  endtask

  task automatic do_read(input int addr, input logic [9:0] hs,
                         output logic oor, output logic [7:0] data);
    disp_if.wave_data_req = 1'b1;
    disp_if.wave_addr     = 12'(addr);
    h_shift               = hs;
    tick();
    oor  = disp_if.outrange;
    data = disp_if.wave_data;
    disp_if.wave_data_req = 1'b0;
  endtask

  task automatic exp_read(input int addr, input logic [9:0] hs,
                          output logic eoor, output logic [7:0] edata);
    int mag;
    int l;
    mag = int'(hs[8:0]);
    l   = addr + CENTRE + (hs[9] ? -mag : mag);
    if (!m_has_frame || l < 0 || l >= DEPTH) begin
      eoor = 1'b1; edata = 8'd0;
    end else begin
      eoor = 1'b0; edata = m_win[l];
    end
  endtask

  task automatic test_reset();
    logic o, eo;
    logic [7:0] d, ed;
    rst_n = 1'b0;
    disp_if.wave_data_req = 1'b0; disp_if.wave_addr = 12'd0; disp_if.wr_over = 1'b0;
    m_has_frame = 1'b0; m_done = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (capture_done !== 1'b0 || trig_found !== 1'b0 || disp_if.outrange !== 1'b1 || disp_if.wave_data !== 8'd0) begin
      n_err++;
      $display("FAIL reset_values: got done=%b tf=%b oor=%b data=%0d, want 0 0 1 0",
               capture_done, trig_found, disp_if.outrange, disp_if.wave_data);
    end
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      int a;
      a = (i == 0) ? 450 : int'($urandom_range(0, 899));
      do_read(a, 10'd0, o, d);
      exp_read(a, 10'd0, eo, ed);
      n_cmp++;
      if (o !== eo || d !== ed) begin
        n_err++;
        $display("FAIL read_before_capture: addr=%0d got oor=%b data=%0d, want oor=%b data=%0d", a, o, d, eo, ed);
      end
    end
  endtask

  task automatic test_rising_ramp();
    logic o, eo;
    logic [7:0] d, ed;
    bit early;
    int i;
    early = 1'b0; i = 0;
    restart(1'b1, 1'b0, 8'd100);
    while (!m_done && i < 5000) begin
      if (capture_done) early = 1'b1;
      feed(8'(i % 256), 1'b1);
      i++;
    end
    n_cmp++;
    if (early || capture_done !== 1'b1 || trig_found !== 1'b1) begin
      n_err++;
      $display("FAIL ramp_done: got early=%0b done=%b tf=%b, want early=0 done=1 tf=1", early, capture_done, trig_found);
    end
    do_read(450, 10'h000, o, d);
    n_cmp++;
    if (o !== 1'b0 || d !== 8'd100) begin
      n_err++;
      $display("FAIL ramp_trig_point: got oor=%b data=%0d, want oor=0 data=100", o, d);
    end
    do_read(440, 10'h00A, o, d);
    n_cmp++;
    if (o !== 1'b0 || d !== 8'd100) begin
      n_err++;
      $display("FAIL ramp_shift_left: got oor=%b data=%0d, want oor=0 data=100", o, d);
    end
    do_read(0, 10'h3FF, o, d);
    n_cmp++;
    if (o !== 1'b1 || d !== 8'd0) begin
      n_err++;
      $display("FAIL ramp_shift_right_oor: got oor=%b data=%0d, want oor=1 data=0", o, d);
    end
    for (int k = 0; k < 16; k++) begin
      int a;
      logic [9:0] hs;
      a = int'($urandom_range(0, 899)); hs = 10'($urandom_range(0, 1023));
      do_read(a, hs, o, d);
      exp_read(a, hs, eo, ed);
      n_cmp++;
      if (o !== eo || d !== ed) begin
        n_err++;
        $display("FAIL ramp_random_read: addr=%0d hs=%h got oor=%b data=%0d, want oor=%b data=%0d", a, hs, o, d, eo, ed);
      end
    end
  endtask

  task automatic test_done_hold();
    logic o, eo;
    logic [7:0] d, ed;
    run = 1'b1;
    for (int i = 0; i < 2000; i++) feed(8'($urandom_range(0, 255)), 1'b1);
    n_cmp++;
    if (capture_done !== 1'b1) begin
      n_err++;
      $display("FAIL done_hold_state: got done=%b, want 1", capture_done);
    end
    for (int k = 0; k < 16; k++) begin
      int a;
      logic [9:0] hs;
      a = int'($urandom_range(0, 899)); hs = 10'($urandom_range(0, 1023));
      do_read(a, hs, o, d);
      exp_read(a, hs, eo, ed);
      n_cmp++;
      if (o !== eo || d !== ed) begin
        n_err++;
        $display("FAIL done_hold_read: addr=%0d hs=%h got oor=%b data=%0d, want oor=%b data=%0d", a, hs, o, d, eo, ed);
      end
    end
    run = 1'b0; disp_if.wr_over = 1'b1; tick(); disp_if.wr_over = 1'b0;
    n_cmp++;
    if (capture_done !== 1'b1) begin
      n_err++;
      $display("FAIL wr_over_run_low: got done=%b, want 1", capture_done);
    end
    run = 1'b1; disp_if.wr_over = 1'b1; tick(); disp_if.wr_over = 1'b0;
    n_cmp++;
    if (capture_done !== 1'b0) begin
      n_err++;
      $display("FAIL wr_over_rearm: got done=%b, want 0", capture_done);
    end
    hist.delete(); m_trig = -1; m_done = 1'b0;
  endtask

  task automatic test_random_capture();
    logic o, eo;
    logic [7:0] d, ed;
    for (int it = 0; it < 3; it++) begin
      bit early;
      int guard;
      early = 1'b0; guard = 0;
      restart(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)));
      while (!m_done && guard < 20000) begin
        if (capture_done) early = 1'b1;
        disp_if.wr_over = ($urandom_range(0, 15) == 0);
        feed(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
        disp_if.wr_over = 1'b0;
        guard++;
      end
      repeat (20) feed(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      n_cmp++;
      if (!m_done || early || capture_done !== 1'b1 || trig_found !== 1'b1) begin
        n_err++;
        $display("FAIL random_capture_done: iter=%0d got model_done=%0b early=%0b done=%b tf=%b, want 1 0 1 1",
                 it, m_done, early, capture_done, trig_found);
      end
      for (int k = 0; k < 16; k++) begin
        int a;
        logic [9:0] hs;
        a = int'($urandom_range(0, 899)); hs = 10'($urandom_range(0, 1023));
        do_read(a, hs, o, d);
        exp_read(a, hs, eo, ed);
        n_cmp++;
        if (o !== eo || d !== ed) begin
          n_err++;
          $display("FAIL random_capture_read: iter=%0d addr=%0d hs=%h got oor=%b data=%0d, want oor=%b data=%0d",
                   it, a, hs, o, d, eo, ed);
        end
      end
    end
  endtask

  task automatic test_abort_falling();
    logic o, eo;
    logic [7:0] d, ed;
    bit early;
    int i;
    restart(1'b1, 1'b0, 8'd100);
    for (int k = 0; k < 1000; k++) feed(8'd50, 1'b1);
    n_cmp++;
    if (capture_done !== 1'b0) begin
      n_err++;
      $display("FAIL normal_stays_armed: got done=%b, want 0", capture_done);
    end
    // Dropping run here aborts the armed capture; the new one starts clean
    restart(1'b1, 1'b1, 8'd100);
    early = 1'b0; i = 0;
    while (!m_done && i < 5000) begin
      if (capture_done) early = 1'b1;
      feed(8'(255 - (i % 256)), 1'b1);
      i++;
    end
    n_cmp++;
    if (early || capture_done !== 1'b1 || trig_found !== 1'b1) begin
      n_err++;
      $display("FAIL falling_done: got early=%0b done=%b tf=%b, want 0 1 1", early, capture_done, trig_found);
    end
    do_read(450, 10'h000, o, d);
    n_cmp++;
    if (o !== 1'b0 || d !== 8'd100) begin
      n_err++;
      $display("FAIL falling_trig_point: got oor=%b data=%0d, want oor=0 data=100", o, d);
    end
    do_read(449, 10'h000, o, d);
    n_cmp++;
    if (o !== 1'b0 || d !== 8'd101) begin
      n_err++;
      $display("FAIL falling_pre_point: got oor=%b data=%0d, want oor=0 data=101", o, d);
    end
    for (int k = 0; k < 16; k++) begin
      int a;
      logic [9:0] hs;
      a = int'($urandom_range(0, 899)); hs = 10'($urandom_range(0, 1023));
      do_read(a, hs, o, d);
      exp_read(a, hs, eo, ed);
      n_cmp++;
      if (o !== eo || d !== ed) begin
        n_err++;
        $display("FAIL falling_random_read: addr=%0d hs=%h got oor=%b data=%0d, want oor=%b data=%0d", a, hs, o, d, eo, ed);
      end
    end
  endtask

  task automatic test_auto();
    logic o;
    logic [7:0] d;
    bit early;
    int guard;
    early = 1'b0; guard = 0;
    restart(1'b0, 1'b0, 8'd100);
    while (!m_done && guard < 70000) begin
      if (capture_done) early = 1'b1;
      feed(8'd50, 1'b1);
      guard++;
    end
    n_cmp++;
    if (!m_done || early || capture_done !== 1'b1 || trig_found !== 1'b0) begin
      n_err++;
      $display("FAIL auto_forced: got model_done=%0b early=%0b done=%b tf=%b, want 1 0 1 0",
               m_done, early, capture_done, trig_found);
    end
    do_read(450, 10'h000, o, d);
    n_cmp++;
    if (o !== 1'b0 || d !== 8'd50) begin
      n_err++;
      $display("FAIL auto_read: got oor=%b data=%0d, want oor=0 data=50", o, d);
    end
  endtask

  task automatic test_reset_mid();
    logic o, eo;
    logic [7:0] d, ed;
    restart(1'b1, 1'b0, 8'd100);
    disp_if.wave_data_req = 1'b1; disp_if.wave_addr = 12'd450; h_shift = 10'd0;
    for (int i = 0; i < 712; i++) feed(8'(i % 256), 1'b1);
    exp_read(450, 10'd0, eo, ed);
    n_cmp++;
    if (disp_if.outrange !== eo || trig_found !== 1'b1) begin
      n_err++;
      $display("FAIL post_fill_before_reset: got oor=%b tf=%b, want oor=%b tf=1", disp_if.outrange, trig_found, eo);
    end
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if (capture_done !== 1'b0 || trig_found !== 1'b0 || disp_if.outrange !== 1'b1 || disp_if.wave_data !== 8'd0) begin
      n_err++;
      $display("FAIL async_reset_mid: got done=%b tf=%b oor=%b data=%0d, want 0 0 1 0",
               capture_done, trig_found, disp_if.outrange, disp_if.wave_data);
    end
    disp_if.wave_data_req = 1'b0;
    tick();
    rst_n = 1'b1;
    m_has_frame = 1'b0; m_done = 1'b0; hist.delete(); m_trig = -1;
    do_read(450, 10'd0, o, d);
    n_cmp++;
    if (o !== 1'b1 || d !== 8'd0) begin
      n_err++;
      $display("FAIL read_after_reset: got oor=%b data=%0d, want oor=1 data=0", o, d);
    end
  endtask

  initial begin
    test_reset();
    test_rising_ramp();
    test_done_hold();
    test_random_capture();
    test_abort_falling();
    test_auto();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wave_capture.md
# wave_capture

Acquisition-side buffer for the DSO display path: samples 8-bit ADC data into a circular RAM, detects the trigger edge, freezes a pre/post-trigger window, and serves that window to the wave display engine through the `wave_addr`/`wave_data` read interface. It re-arms only when the display reports a finished frame (`wr_over`), so a frozen capture is never overwritten mid-frame. It sits between the ADC sampling logic and the wave display / HDMI pixel pipeline, in the `hdmi_pclk` domain.

## Interface
- `ADDR_W`, 10: RAM address width; DEPTH = 2^ADDR_W = 1024 samples.
- `PRE_TRIG`, 512: samples kept before the trigger sample; the trigger sample sits at logical index PRE_TRIG.
- `DISP_POINTS`, 900: display points per frame; centre offset C = (DEPTH-DISP_POINTS)/2 = 62.
- `AUTO_SAMPLES`, 16'd65535: valid samples spent in ARMED before an auto-mode forced trigger.
- `hdmi_pclk`  in  1  sole clock. One clock; reset is asynchronous and active-low.
- `rst_n`  in  1  asynchronous active-low reset.
- `ad_data`  in  8  ADC sample.
- `ad_valid`  in  1  sample strobe; one sample per high cycle.
- `run`  in  1  1 = acquire, 0 = stop/hold.
- `trig_mode`  in  1  0 = auto (forced trigger on timeout), 1 = normal.
- `trig_edge`  in  1  0 = rising, 1 = falling.
- `trig_level`  in  8  trigger threshold.
- `h_shift`  in  10  horizontal shift, sign-magnitude: bit[9]=0 shifts the wave left, bit[9]=1 shifts it right; bits[8:0] magnitude.
- `wave_data_req`  in  1  display read enable.
- `wave_addr`  in  12  display point index, 0..DISP_POINTS-1.
- `wr_over`  in  1  one-cycle pulse: display frame finished.
- `wave_data`  out  8  sample read back, 1-cycle latency.
- `outrange`  out  1  read point falls outside the captured window or no valid frame; 1-cycle latency, aligned with `wave_data`.
- `capture_done`  out  1  high in DONE.
- `trig_found`  out  1  last capture was a real trigger (0 = forced).

## Operation
- States: IDLE, PRE_FILL, ARMED, POST_FILL, DONE. Reset → IDLE.
- IDLE: on `run`=1 → PRE_FILL; clear pre count, timeout count and the write pointer.
- PRE_FILL: each `ad_valid` writes `ad_data` at wr_ptr and increments wr_ptr mod DEPTH and the pre count. After PRE_TRIG samples → ARMED.
- ARMED: keep writing circularly. Trigger on a valid sample c with previous valid sample p. Rising edge: p < level and c ≥ level. Falling edge: p > level and c ≤ level. On trigger: trig_ptr ← wr_ptr of c, trig_found ← 1 → POST_FILL. In auto mode, the timeout count of valid samples reaching AUTO_SAMPLES forces a trigger at the current sample with trig_found ← 0. A real trigger on the same sample wins.
- POST_FILL: write DEPTH-PRE_TRIG-1 = 511 further samples → DONE. `run` is ignored here.
- DONE: writes disabled; `capture_done`=1. On `wr_over`=1 with `run`=1 → PRE_FILL. With `run`=0, hold in DONE.
- `run`=0 in PRE_FILL or ARMED → IDLE (abort).
- Read mapping: start_ptr = trig_ptr − PRE_TRIG mod DEPTH. L = wave_addr + C + mag when bit[9]=0, or wave_addr + C − mag when bit[9]=1. L is computed 13-bit signed.
  - L < 0 or L ≥ DEPTH → `outrange`=1, `wave_data`=0.
  - Otherwise RAM addr = (start_ptr + L) mod DEPTH.
  - `wave_data_req`=0 → `outrange`=1.
- has_frame flag: 0 from reset until the first entry to DONE. While 0, `outrange` is forced to 1.
- Reads are served in every state. Tearing during recapture is accepted.

## Timing
- Reset values: `wave_data`=0, `outrange`=1, `capture_done`=0, `trig_found`=0, state IDLE.
- RAM write occurs on the same edge that samples `ad_valid`=1.
- Read: address on cycle N → `wave_data`/`outrange` valid on N+1.
- RAM is read-first: a read and write to the same address in one cycle returns old data.
- State transitions are registered. `capture_done` rises one cycle after the final post-trigger write.
- `wr_over` that arrives in any state other than DONE is ignored and not remembered.
- Reset mid-capture: everything returns to reset values; RAM contents are don't-care.

## Structure
- Shared package `wave_pkg`: state encoding, the h_shift sign convention, and the default PRE_TRIG/DISP_POINTS constants, so `wave_capture` and the display engine agree.
- Sub-module `wave_ram`: simple dual-port, DEPTH×8, one write port and one registered read port, read-first behaviour.

## Test plan
- Rising ramp 0..255 repeating, `ad_valid` every cycle, level 100, rising, normal → DONE. `wave_addr`=450, h_shift=0 → `wave_data`=100 next cycle, `trig_found`=1.
- Same capture, h_shift = 10'h00A (left 10) → `wave_addr`=440 returns 100. h_shift = 10'h3FF (right 511), `wave_addr`=0 → `outrange`=1.
- Constant input 50, level 100, auto mode → forced trigger after 65535 ARMED samples, DONE, `trig_found`=0. Same input in normal mode → stays ARMED indefinitely.
- Falling ramp, level 100, falling edge → sample at L=512 is 100. Sample at L=511 is 101.
- In DONE, feed 2000 samples → RAM unchanged. Pulse `wr_over` with `run`=1 → PRE_FILL next cycle. Drop `run` in ARMED → IDLE.
- Reads after reset, before any capture → `outrange`=1, `wave_data`=0. Assert `rst_n`=0 in POST_FILL → all outputs return to reset values immediately.
